// File: rtl/counter_share_ctrl.sv
// rtl/counter_share_ctrl.sv - round-robin sharing of one interval counter between two requesters (optional pause: CSC_PAUSE_EN)
module counter_share_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] len0,
    input  logic             req1,
    input  logic [WIDTH-1:0] len1,
`ifdef CSC_PAUSE_EN
    input  logic             pause,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic             done0,
    output logic             done1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic             last;
    logic [WIDTH-1:0] len_r;
    logic             pause_w;
    logic             any_req;
    logic             winner;
    logic             owner_req;
    logic             terminal;

`ifdef CSC_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // The owner is always the last winner, so last doubles as the owner index.
    assign any_req   = req0 | req1;
    assign winner    = (req0 & req1) ? ~last : req1;
    assign owner_req = last ? req1 : req0;

    // len_r == 0 wraps the terminal to all-ones, giving a full 2^WIDTH interval.
    assign terminal  = (cnt == (len_r - WIDTH'(1)));

    assign busy      = (state != ST_IDLE);

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            len_r <= '0;
            cnt   <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        len_r <= winner ? len1 : len0;
                        gnt0  <= ~winner;
                        gnt1  <= winner;
                        last  <= winner;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!owner_req) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                    end else if (!pause_w) begin
                        if (terminal) begin
                            state <= ST_DONE;
                            cnt   <= '0;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                            done0 <= ~last;
                            done1 <= last;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb/tb_counter_share_ctrl.sv - scoreboard bench for counter_share_ctrl
module tb_counter_share_ctrl;

    localparam int WIDTH = 5;

    logic             clk;
    logic             clr_n;
    logic             req0;
    logic [WIDTH-1:0] len0;
    logic             req1;
    logic [WIDTH-1:0] len1;
    logic             pause;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic [WIDTH-1:0] cnt;
    logic             done0;
    logic             done1;

    typedef struct {
        bit is_done;
        bit id;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    bit  pg0 = 1'b0;
    bit  pg1 = 1'b0;

    counter_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .req0  (req0),
        .len0  (len0),
        .req1  (req1),
        .len1  (len1),
`ifdef CSC_PAUSE_EN
        .pause (pause),
`endif
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .cnt   (cnt),
        .done0 (done0),
        .done1 (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input bit is_done, input bit id);
        ev_t e;
        e.is_done = is_done;
        e.id      = id;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
    endtask

    task automatic observe(input bit is_done, input bit id);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: actual=%s%0d required=none at %0t",
                     is_done ? "done" : "gnt", id, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done || e.id != id) begin
                errors++;
                $display("FAIL event_order: actual=%s%0d required=%s%0d at %0t",
                         is_done ? "done" : "gnt", id, e.is_done ? "done" : "gnt", e.id, $time);
            end
        end
    endtask

    // Monitor: outputs change on negedge, sampled here on posedge.
    always @(posedge clk) begin
        if (clr_n === 1'b1) begin
            if (gnt0 && !pg0) observe(1'b0, 1'b0);
            if (gnt1 && !pg1) observe(1'b0, 1'b1);
            if (done0) observe(1'b1, 1'b0);
            if (done1) observe(1'b1, 1'b1);
            chk("gnt_exclusive", int'(gnt0 & gnt1), 0);
            chk("done_exclusive", int'(done0 & done1), 0);
            chk("busy_vs_state", int'(busy), int'(gnt0 | gnt1 | done0 | done1));
        end
        pg0 = gnt0;
        pg1 = gnt1;
    end

    task automatic do_reset();
        @(posedge clk);
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
    endtask

    initial begin
        clr_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        len0  = '0;
        len1  = '0;
        pause = 1'b0;
        step();
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done0 | done1), 0);
        clr_n = 1'b1;

        // Single request, len 4
        req0 = 1'b1;
        len0 = 5'd4;
        expect_ev(1'b0, 1'b0);
        step();
        chk("t1_gnt0", int'(gnt0), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_cnt", int'(cnt), i);
            if (i == 3) expect_ev(1'b1, 1'b0);
            step();
        end
        chk("t1_done0", int'(done0), 1);
        chk("t1_gnt0_drop", int'(gnt0), 0);
        chk("t1_cnt_clear", int'(cnt), 0);
        chk("t1_busy_done", int'(busy), 1);
        req0 = 1'b0;
        step();
        chk("t1_done0_clear", int'(done0), 0);
        chk("t1_busy_idle", int'(busy), 0);

        // Tie after reset: strict alternation
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        len0 = 5'd2;
        len1 = 5'd3;
        expect_ev(1'b0, 1'b0);
        expect_ev(1'b1, 1'b0);
        expect_ev(1'b0, 1'b1);
        expect_ev(1'b1, 1'b1);
        expect_ev(1'b0, 1'b0);
        step();
        chk("t2_first_gnt0", int'(gnt0), 1);
        for (int i = 0; i < 9; i++) step();
        chk("t2_regrant_gnt0", int'(gnt0), 1);
        chk("t2_regrant_cnt", int'(cnt), 0);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("t2_abort_busy", int'(busy), 0);

        // len 0: full 32-tick interval with wrap
        req1 = 1'b1;
        len1 = 5'd0;
        expect_ev(1'b0, 1'b1);
        step();
        for (int i = 0; i < 32; i++) begin
            chk("t3_cnt", int'(cnt), i);
            chk("t3_no_early_done", int'(done1), 0);
            if (i == 31) expect_ev(1'b1, 1'b1);
            step();
        end
        chk("t3_done1", int'(done1), 1);
        chk("t3_cnt_wrap", int'(cnt), 0);
        req1 = 1'b0;
        step();
        chk("t3_done1_once", int'(done1), 0);

        // Abort at cnt 5 with req1 pending
        req0 = 1'b1;
        req1 = 1'b1;
        len0 = 5'd10;
        len1 = 5'd7;
        expect_ev(1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) step();
        chk("t4_cnt5", int'(cnt), 5);
        req0 = 1'b0;
        len0 = 5'd1;
        step();
        chk("t4_abort_gnt0", int'(gnt0), 0);
        chk("t4_abort_cnt", int'(cnt), 0);
        chk("t4_abort_busy", int'(busy), 0);
        chk("t4_no_done0", int'(done0), 0);
        expect_ev(1'b0, 1'b1);
        step();
        chk("t4_gnt1", int'(gnt1), 1);
        req1 = 1'b0;
        step();
        chk("t4_abort_gnt1", int'(gnt1), 0);

        // Asynchronous reset mid-run
        req0 = 1'b1;
        len0 = 5'd10;
        expect_ev(1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) step();
        chk("t5_cnt3", int'(cnt), 3);
        #2 clr_n = 1'b0;
        #1;
        chk("t5_async_gnt0", int'(gnt0), 0);
        chk("t5_async_cnt", int'(cnt), 0);
        chk("t5_async_busy", int'(busy), 0);
        chk("t5_async_done", int'(done0), 0);
        step();
        clr_n = 1'b1;
        req1  = 1'b1;
        len0  = 5'd3;
        len1  = 5'd3;
        expect_ev(1'b0, 1'b0);
        step();
        chk("t5_tie_gnt0", int'(gnt0), 1);
        chk("t5_tie_gnt1", int'(gnt1), 0);
        req0 = 1'b0;
        req1 = 1'b0;
        step();

`ifdef CSC_PAUSE_EN
        // Pause for 3 cycles at cnt 2
        do_reset();
        req0 = 1'b1;
        len0 = 5'd5;
        expect_ev(1'b0, 1'b0);
        step();
        step();
        step();
        chk("t6_cnt2", int'(cnt), 2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_hold", int'(cnt), 2);
            chk("t6_hold_gnt0", int'(gnt0), 1);
        end
        pause = 1'b0;
        step();
        chk("t6_cnt3", int'(cnt), 3);
        step();
        chk("t6_cnt4", int'(cnt), 4);
        expect_ev(1'b1, 1'b0);
        step();
        chk("t6_done0_at_8", int'(done0), 1);
        req0 = 1'b0;
        step();
`endif

        step();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_share_ctrl.md
Name: counter_share_ctrl

Overview:
- Arbiter and sequencer that shares one WIDTH-bit interval counter between two requesters.
- Each requester asks for an interval of len ticks. The block grants round-robin, runs the counter, then pulses a per-requester done.
- Sits between client logic and the counter datapath. It replaces hard-wired NAND-reset moduli with a per-request programmable terminal count.

Parameters:
- WIDTH, 5, counter and length width in bits.

Ports:
- clk  input  1  clock; all state updates on falling edge (negedge), matching the team's flop convention.
- clr_n  input  1  reset: asynchronous, active-low.
- req0  input  1  requester 0 interval request (level).
- len0  input  WIDTH  requester 0 interval length, sampled at grant.
- req1  input  1  requester 1 interval request (level).
- len1  input  WIDTH  requester 1 interval length, sampled at grant.
- gnt0  output  1  requester 0 owns the counter.
- gnt1  output  1  requester 1 owns the counter.
- busy  output  1  high in RUN or DONE.
- cnt  output  WIDTH  current counter value.
- done0  output  1  one-cycle pulse: requester 0 interval complete.
- done1  output  1  one-cycle pulse: requester 1 interval complete.

Behaviour:
- Reset (clr_n=0, asynchronous, independent of clk):
  - State=IDLE, cnt=0, gnt0=gnt1=0, done0=done1=0, busy=0.
  - Round-robin pointer last=1, so req0 wins the first tie.
- States: IDLE, RUN, DONE, 2-bit encoding; unused encoding returns to IDLE.
- IDLE:
  - At a negedge with any req high, pick a winner.
    - Only one req high: that requester wins.
    - Both high: the requester not equal to last wins.
  - On that edge: latch the winner's len into len_r, set cnt=0, assert gnt_winner, set last=winner, go to RUN.
  - No req: stay in IDLE, cnt stays 0.
- RUN:
  - Each negedge: cnt=cnt+1, modulo 2^WIDTH.
  - When cnt==len_r-1 at the edge: go to DONE, cnt=0, drop gnt, assert done_winner.
  - len_r=0 means a full 2^WIDTH-tick interval; terminal is cnt==2^WIDTH-1.
  - Latency: grant edge E0 -> done high from edge E0+len to E0+len+1.
- DONE:
  - Exactly one cycle long, then IDLE.
  - done_x clears on the next edge.
  - req lines are not sampled in DONE.
- Abort:
  - If the owner's req is low at a RUN edge: go to IDLE immediately, cnt=0, gnt=0, no done pulse.
  - last still points to the aborted owner.
- Re-request:
  - A req still high in IDLE after DONE is a new request and re-arbitrates.
  - If both reqs are pending, the other requester wins (fairness).
- Ignored inputs:
  - The non-owner's req is ignored during RUN and DONE.
  - len changes after grant are ignored (len_r is held).
- Invariants:
  - gnt0 and gnt1 are never both high.
  - done0 and done1 are never both high.
  - busy = (state != IDLE).
- Reset mid-RUN: asynchronously returns every output to its reset value; no done pulse.

Optional Feature:
- Macro: CSC_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - In RUN with pause=1: cnt holds, terminal check suppressed, owner keeps its grant.
  - Abort on req low still takes priority over pause.
  - pause is ignored in IDLE and DONE.
- Undefined: port absent; behaviour identical to pause tied to 0.

Test Plan:
- Reset then req0=1, len0=4 -> gnt0 after the first negedge; cnt 0,1,2,3; done0 high exactly one cycle at the 4th edge after grant; busy low one edge later.
- req0=req1=1 together after reset, len0=2, len1=3, both held -> order gnt0, done0, gnt1, done1, gnt0 (strict alternation).
- req1=1, len1=0 -> 32 RUN cycles; cnt wraps 31->0 at the terminal edge; done1 fires once.
- req0=1, len0=10; drop req0 at cnt=5 -> IDLE next edge, cnt=0, gnt0=0, done0 never asserts; a pending req1 is granted next.
- clr_n pulsed low mid-RUN at cnt=3 (between edges) -> gnt, cnt, busy go to 0 immediately; no done pulse; after release, req0 is granted first on a tie.
- With CSC_PAUSE_EN: len0=5, pause=1 for 3 cycles at cnt=2 -> cnt holds at 2; done0 arrives 3 cycles later than without pause (8 edges after grant).
